// File: rtl/letter_buffer_ctrl.sv
// Morse letter line buffer: append, backspace, clear and scroll-left
// sequencing with a single pending slot for letters arriving while busy.
module letter_buffer_ctrl #(
    parameter int         DEPTH  = 16,
    parameter int         ADDR_W = 4,
    parameter logic [4:0] BLANK  = 5'b11111
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        LETTER_IN,
    input  logic              STROBE_IN,
    input  logic              BACKSPACE,
    input  logic              CLEAR,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [4:0]        RD_DATA,
    output logic [ADDR_W:0]   COUNT,
    output logic              BUSY,
    output logic              DROP
);

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_CLR
    } state_t;

    state_t            r_state;
    logic [4:0]        r_mem [DEPTH];
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [4:0]        r_scroll;
    logic [4:0]        r_pend;
    logic              r_pend_v;
    logic              r_clr_pend;
    logic              r_strobe_d;
    logic              r_busy;
    logic              r_drop;

    logic              w_rise;
    logic              w_clear;
    logic              w_app;
    logic [4:0]        w_app_d;
    logic              w_full;
    logic [ADDR_W-1:0] w_idx_n;
    logic [ADDR_W:0]   w_cm1;

    assign w_rise  = STROBE_IN & ~r_strobe_d;
    assign w_clear = CLEAR | r_clr_pend;
    // A held letter always beats backspace and a fresh strobe
    assign w_app   = ~w_clear & (r_pend_v | (~BACKSPACE & w_rise));
    assign w_app_d = r_pend_v ? r_pend : LETTER_IN;
    assign w_full  = (r_count == L_DEPTH);
    assign w_idx_n = r_idx + 1'b1;
    assign w_cm1   = r_count - 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= BLANK;
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_scroll   <= BLANK;
            r_pend     <= BLANK;
            r_pend_v   <= 1'b0;
            r_clr_pend <= 1'b0;
            r_strobe_d <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_strobe_d <= STROBE_IN;
            r_drop     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_clear) begin
                        // Older held letter is discarded; a same-cycle one survives
                        r_pend_v   <= w_rise;
                        r_pend     <= LETTER_IN;
                        r_clr_pend <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= S_CLR;
                        r_busy     <= 1'b1;
                    end else if (w_app) begin
                        if (!w_full) begin
                            r_mem[r_count[ADDR_W-1:0]] <= w_app_d;
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_scroll <= w_app_d;
                            r_idx    <= '0;
                            r_state  <= S_SCROLL;
                            r_busy   <= 1'b1;
                        end
                        if (r_pend_v) begin
                            r_pend_v <= w_rise;
                            r_pend   <= LETTER_IN;
                        end
                    end else if (BACKSPACE) begin
                        if (r_count != '0) begin
                            r_mem[w_cm1[ADDR_W-1:0]] <= BLANK;
                            r_count <= w_cm1;
                        end
                        if (w_rise) begin
                            r_pend_v <= 1'b1;
                            r_pend   <= LETTER_IN;
                        end
                    end
                end
                S_SCROLL, S_CLR: begin
                    if (w_rise) begin
                        if (!r_pend_v) begin
                            r_pend_v <= 1'b1;
                            r_pend   <= LETTER_IN;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                    if (r_state == S_SCROLL) begin
                        if (CLEAR) r_clr_pend <= 1'b1;
                        if (r_idx == L_LAST) begin
                            r_mem[r_idx] <= r_scroll;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_mem[r_idx] <= r_mem[w_idx_n];
                            r_idx        <= w_idx_n;
                        end
                    end else begin
                        r_mem[r_idx] <= BLANK;
                        if (r_idx == L_LAST) begin
                            r_count <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= w_idx_n;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RD_DATA = ({1'b0, RD_ADDR} >= L_DEPTH) ? BLANK : r_mem[RD_ADDR];
    assign COUNT   = r_count;
    assign BUSY    = r_busy;
    assign DROP    = r_drop;

endmodule

// File: tb/tb_letter_buffer_ctrl.sv
// Directed bench for letter_buffer_ctrl: vector table plus
// hand-written scroll, pending, drop, clear and reset sequences.
module tb_letter_buffer_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] LETTER_IN;
    logic       STROBE_IN;
    logic       BACKSPACE;
    logic       CLEAR;
    logic [3:0] RD_ADDR;
    logic [4:0] RD_DATA;
    logic [4:0] COUNT;
    logic       BUSY;
    logic       DROP;

    int checks = 0;
    int errors = 0;
    int drops  = 0;

    localparam int OP_STB = 0;
    localparam int OP_BS  = 1;
    localparam int OP_NOP = 2;

    typedef struct {
        int         op;
        logic [4:0] code;
        logic [3:0] addr;
        int         cnt;
        logic [4:0] dat;
    } vec_t;

    vec_t tbl[9];

    letter_buffer_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LETTER_IN (LETTER_IN),
        .STROBE_IN (STROBE_IN),
        .BACKSPACE (BACKSPACE),
        .CLEAR     (CLEAR),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .COUNT     (COUNT),
        .BUSY      (BUSY),
        .DROP      (DROP)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (DROP) drops++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int a, output int d);
        RD_ADDR = 4'(a);
        #1;
        d = int'(RD_DATA);
    endtask

    task automatic strobe(input int code);
        LETTER_IN = 5'(code);
        STROBE_IN = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        tick();
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) strobe(base + i);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL busy_timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic chk_blank(input string name);
        int d;
        for (int a = 0; a < 16; a++) begin
            rd(a, d);
            chk(name, d, 31);
        end
    endtask

    initial begin
        int d;
        int n;
        int d0;

        tbl[0] = '{OP_STB, 5'd0, 4'd0, 1, 5'd0};
        tbl[1] = '{OP_STB, 5'd1, 4'd1, 2, 5'd1};
        tbl[2] = '{OP_STB, 5'd2, 4'd2, 3, 5'd2};
        tbl[3] = '{OP_NOP, 5'd0, 4'd3, 3, 5'd31};
        tbl[4] = '{OP_NOP, 5'd0, 4'd0, 3, 5'd0};
        tbl[5] = '{OP_BS,  5'd0, 4'd2, 2, 5'd31};
        tbl[6] = '{OP_BS,  5'd0, 4'd1, 1, 5'd31};
        tbl[7] = '{OP_BS,  5'd0, 4'd0, 0, 5'd31};
        tbl[8] = '{OP_BS,  5'd0, 4'd0, 0, 5'd31};

        RESET     = 1'b1;
        LETTER_IN = '0;
        STROBE_IN = 1'b0;
        BACKSPACE = 1'b0;
        CLEAR     = 1'b0;
        RD_ADDR   = '0;
        tick();
        tick();
        RESET = 1'b0;
        tick();

        chk("rst_count", int'(COUNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_drop", int'(DROP), 0);
        rd(0, d);
        chk("rst_cell0", d, 31);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].op == OP_STB) begin
                strobe(int'(tbl[i].code));
            end else if (tbl[i].op == OP_BS) begin
                BACKSPACE = 1'b1;
                tick();
                BACKSPACE = 1'b0;
                tick();
            end
            tick();
            tick();
            chk($sformatf("vec%0d_count", i), int'(COUNT), tbl[i].cnt);
            chk($sformatf("vec%0d_busy", i), int'(BUSY), 0);
            rd(int'(tbl[i].addr), d);
            chk($sformatf("vec%0d_data", i), d, int'(tbl[i].dat));
        end

        // Full line, one more letter scrolls left
        fill(16, 0);
        chk("full_count", int'(COUNT), 16);
        LETTER_IN = 5'd20;
        STROBE_IN = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        wait_idle(n);
        chk("scroll1_len", n, 16);
        rd(0, d);
        chk("scroll1_a0", d, 1);
        rd(14, d);
        chk("scroll1_a14", d, 15);
        rd(15, d);
        chk("scroll1_a15", d, 20);
        chk("scroll1_count", int'(COUNT), 16);

        // Pending letter during scroll, second letter dropped
        d0 = drops;
        LETTER_IN = 5'd30;
        STROBE_IN = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        tick();
        strobe(21);
        strobe(22);
        wait_idle(n);
        tick();
        chk("pend_rescroll", int'(BUSY), 1);
        wait_idle(n);
        chk("scroll2_len", n, 16);
        chk("drop_once", drops - d0, 1);
        rd(0, d);
        chk("scroll2_a0", d, 3);
        rd(14, d);
        chk("scroll2_a14", d, 30);
        rd(15, d);
        chk("scroll2_a15", d, 21);
        chk("scroll2_count", int'(COUNT), 16);

        // Clear from a full line
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        wait_idle(n);
        chk("clr_len", n, 16);
        chk("clr_count", int'(COUNT), 0);
        chk_blank("clr_cells");

        // Clear and strobe in the same idle cycle
        LETTER_IN = 5'd7;
        STROBE_IN = 1'b1;
        CLEAR     = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        CLEAR     = 1'b0;
        chk("clrstb_busy", int'(BUSY), 1);
        wait_idle(n);
        chk("clrstb_len", n, 16);
        tick();
        chk("clrstb_count", int'(COUNT), 1);
        rd(0, d);
        chk("clrstb_a0", d, 7);

        // Reset in the middle of a scroll
        fill(15, 1);
        chk("fill2_count", int'(COUNT), 16);
        LETTER_IN = 5'd9;
        STROBE_IN = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midscroll_busy", int'(BUSY), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mrst_busy", int'(BUSY), 0);
        chk("mrst_count", int'(COUNT), 0);
        chk("mrst_drop", int'(DROP), 0);
        chk_blank("mrst_cells");
        tick();
        chk("mrst_stay_idle", int'(BUSY), 0);

        // Clear requested during scroll runs right after it
        fill(16, 0);
        LETTER_IN = 5'd4;
        STROBE_IN = 1'b1;
        tick();
        STROBE_IN = 1'b0;
        tick();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        wait_idle(n);
        tick();
        chk("clrpend_busy", int'(BUSY), 1);
        wait_idle(n);
        chk("clrpend_len", n, 16);
        chk("clrpend_count", int'(COUNT), 0);
        rd(15, d);
        chk("clrpend_a15", d, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
